cacheline_arbiter: RTL and testbench

//   Shares one cacheline_adaptor (256-bit line side) between the I-cache (read-only) and D-cache
//   (read/write). Sits between the two caches' memory ports and the adaptor's line interface;
//   one transaction in flight at a time, full line per grant, no reordering.

---
 rtl/cacheline_arbiter_pkg.sv | 28 ++
 rtl/cacheline_arb_select.sv | 37 +++
 rtl/cacheline_arbiter.sv | 134 +++++++++++++
 tb/tb_cacheline_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_arbiter_pkg
// Description : Shared types and default widths for the I/D cacheline arbiter.
//               ARB_ROUND_ROBIN_EN (optional) selects round-robin arbitration
//               in the users of this package.
// Revision    : 1.0 - initial release
// ============================================================================
package cacheline_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;

  // Arbiter FSM states; SERVE_x also names the winner from the selector.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Operation latched for the granted transaction.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

endpackage
`default_nettype wire

// File: rtl/cacheline_arb_select.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_arb_select
// Description : Combinational winner pick between the I-cache and D-cache
//               requests. Default build: fixed priority, D over I.
//               ARB_ROUND_ROBIN_EN: on a contest, the side not served last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_arb_select
  import cacheline_arbiter_pkg::*;
(
  input  logic       i_icache_req,
  input  logic       i_dcache_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       i_rr_favour_icache,
`endif
  output arb_state_t o_grant
);

  // Pick the winner; IDLE means nobody is asking.
  always_comb begin
    o_grant = IDLE;
    if (i_icache_req && i_dcache_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      o_grant = i_rr_favour_icache ? SERVE_I : SERVE_D;
`else
      o_grant = SERVE_D;
`endif
    end else if (i_dcache_req) begin
      o_grant = SERVE_D;
    end else if (i_icache_req) begin
      o_grant = SERVE_I;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cacheline_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_arbiter
// Description : Shares one cacheline adaptor between the I-cache (read only)
//               and the D-cache (read/writeback). One full-line transaction in
//               flight, request latched at grant, completion pulse steered back
//               to the owner. Optional macro ARB_ROUND_ROBIN_EN enables
//               round-robin arbitration instead of fixed D-over-I priority.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_arbiter
  import cacheline_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        r_state;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [LINE_W-1:0] r_mem_wdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic              r_rr_favour_i;   // 1: I-cache wins the next contest
`endif

  arb_state_t        w_grant;
  arb_op_t           w_d_op;
  logic              w_dcache_req;

  // A writeback outranks a read if the D-cache ever raises both.
  assign w_dcache_req = dcache_read | dcache_write;
  assign w_d_op       = dcache_write ? OP_WRITE : OP_READ;

  cacheline_arb_select u_select (
    .i_icache_req       (icache_read),
    .i_dcache_req       (w_dcache_req),
`ifdef ARB_ROUND_ROBIN_EN
    .i_rr_favour_icache (r_rr_favour_i),
`endif
    .o_grant            (w_grant)
  );

  // Grant FSM: latch the winner's request in IDLE, hold it until mem_resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_favour_i <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant == SERVE_D) begin
            r_mem_read    <= (w_d_op == OP_READ);
            r_mem_write   <= (w_d_op == OP_WRITE);
            r_mem_address <= dcache_address;
            if (w_d_op == OP_WRITE) begin
              r_mem_wdata <= dcache_wdata;
            end
            r_state       <= SERVE_D;
          end else if (w_grant == SERVE_I) begin
            r_mem_read    <= 1'b1;
            r_mem_write   <= 1'b0;
            r_mem_address <= icache_address;
            r_state       <= SERVE_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_state       <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_favour_i <= (r_state == SERVE_D);
`endif
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;

  // Only the completion pulse is steered; both caches see the adaptor line.
  assign icache_resp  = (r_state == SERVE_I) & mem_resp;
  assign dcache_resp  = (r_state == SERVE_D) & mem_resp;
  assign icache_rdata = mem_rdata;
  assign dcache_rdata = mem_rdata;

`ifndef SYNTHESIS
  // Flag protocol violations by the D-cache or the adaptor.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(dcache_read && dcache_write));
      assert (!(mem_resp && (r_state == IDLE)));
      assert (!(r_mem_read && r_mem_write));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_arbiter
// Description : Self-checking bench for cacheline_arbiter. A transaction-level
//               model (who owns the adaptor, what was latched, line memory)
//               predicts every output; the bench also plays both caches and
//               the adaptor. Honours ARB_ROUND_ROBIN_EN for the contest rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_read;
  logic [31:0]  icache_address;
  logic [255:0] icache_rdata;
  logic         icache_resp;
  logic         dcache_read;
  logic         dcache_write;
  logic [31:0]  dcache_address;
  logic [255:0] dcache_wdata;
  logic [255:0] dcache_rdata;
  logic         dcache_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  cacheline_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model of the shared adaptor.
  bit           m_busy   = 1'b0;
  int           m_owner  = 0;      // 1 = I-cache, 2 = D-cache
  bit           m_is_write = 1'b0;
  logic [31:0]  m_addr   = '0;
  logic [255:0] m_wdata  = '0;
  bit           m_last_d = 1'b0;   // D served most recently
  logic [255:0] mem_model [logic [31:0]];
  int           adp_cnt  = -1;
  int           lat_fixed = 0;     // 0 = random latency 1..6
  bit           resp_now = 1'b0;
  bit           just_dropped_i = 1'b0;
  bit           just_dropped_d = 1'b0;
  int           n_req_i = 0, n_req_d = 0, n_resp_i = 0, n_resp_d = 0;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem_model.exists(a)) return mem_model[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = a ^ (32'h5A5A_0000 + 32'(k));
    return l;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req_i(input logic [31:0] a);
    icache_read    = 1'b1;
    icache_address = a;
    n_req_i++;
  endtask

  task automatic req_d(input bit wr, input logic [31:0] a, input logic [255:0] wd);
    dcache_read    = !wr;
    dcache_write   = wr;
    dcache_address = a;
    dcache_wdata   = wd;
    n_req_d++;
  endtask

  // One clock: model the edge, check registered outputs, act as caches and
  // adaptor for the new cycle, then check the combinational response.
  task automatic tick();
    bit d_want, i_want, pick_d, was_rst;
    int done_owner;
    @(posedge clk);
    #1;
    done_owner = 0;
    was_rst = (rst === 1'b1);
    d_want  = dcache_read || dcache_write;
    i_want  = icache_read;
    if (was_rst) begin
      m_busy = 1'b0; m_last_d = 1'b0; adp_cnt = -1;
    end else if (m_busy) begin
      if (resp_now) begin
        m_busy     = 1'b0;
        done_owner = m_owner;
        m_last_d   = (m_owner == 2);
        if (m_is_write) mem_model[m_addr] = m_wdata;
      end
    end else if (d_want || i_want) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_d = d_want && (!i_want || !m_last_d);
`else
      pick_d = d_want;
`endif
      m_busy     = 1'b1;
      m_owner    = pick_d ? 2 : 1;
      m_is_write = pick_d && dcache_write;
      m_addr     = pick_d ? dcache_address : icache_address;
      m_wdata    = dcache_wdata;
    end
    chk("rd_wr_exclusive", mem_read & mem_write, 0);
    chk("mem_read", mem_read, m_busy && !m_is_write);
    chk("mem_write", mem_write, m_busy && m_is_write);
    if (m_busy) begin
      chk("mem_address", mem_address, m_addr);
      if (m_is_write) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (was_rst) begin
      chk("rst_mem_address", mem_address, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end
    just_dropped_i = (done_owner == 1);
    just_dropped_d = (done_owner == 2);
    if (just_dropped_i) icache_read = 1'b0;
    if (just_dropped_d) begin dcache_read = 1'b0; dcache_write = 1'b0; end
    resp_now = 1'b0;
    mem_resp = 1'b0;
    for (int k = 0; k < 8; k++) mem_rdata[k*32 +: 32] = $urandom();
    if (m_busy && !rst) begin
      if (adp_cnt < 0) adp_cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
      adp_cnt--;
      if (adp_cnt == 0) begin
        resp_now = 1'b1;
        mem_resp = 1'b1;
        adp_cnt  = -1;
        if (!m_is_write) mem_rdata = line_of(m_addr);
      end
    end
    #2;
    chk("icache_resp", icache_resp, resp_now && (m_owner == 1));
    chk("dcache_resp", dcache_resp, resp_now && (m_owner == 2));
    if (resp_now) begin
      if (m_owner == 1) n_resp_i++; else n_resp_d++;
      if (!m_is_write) begin
        if (m_owner == 1) chk("icache_rdata", icache_rdata, line_of(m_addr));
        else              chk("dcache_rdata", dcache_rdata, line_of(m_addr));
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((icache_read || dcache_read || dcache_write || m_busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", icache_read | dcache_read | dcache_write | m_busy, 0);
  endtask

  initial begin
    logic [255:0] w_line;
    logic [31:0]  exp_addr;
    int           issued;
    int           cyc;

    rst = 1'b1; icache_read = 1'b0; icache_address = '0;
    dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = '0; dcache_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed: I-only read, adaptor answers in the sixth cycle.
    lat_fixed = 6;
    req_i(32'h0000_1040);
    tick();
    chk("t1_mem_read", mem_read, 1);
    chk("t1_mem_address", mem_address, 32'h0000_1040);
    repeat (5) tick();
    chk("t1_icache_resp", icache_resp, 1);
    chk("t1_dcache_resp", dcache_resp, 0);
    chk("t1_rdata", icache_rdata, line_of(32'h0000_1040));
    tick();
    chk("t1_read_dropped", mem_read, 0);

    // Directed: D writeback held until the adaptor answers.
    lat_fixed = 4;
    for (int k = 0; k < 8; k++) w_line[k*32 +: 32] = $urandom();
    req_d(1'b1, 32'h8000_0020, w_line);
    tick();
    chk("t2_mem_write", mem_write, 1);
    chk("t2_mem_wdata", mem_wdata, w_line);
    repeat (3) tick();
    chk("t2_dcache_resp", dcache_resp, 1);
    chk("t2_wdata_held", mem_wdata, w_line);
    tick();
    chk("t2_write_dropped", mem_write, 0);

    // Directed: requester address changes after the grant.
    lat_fixed = 5;
    req_d(1'b0, 32'h3000_0040, '0);
    tick();
    dcache_address = 32'hDEAD_BEE0;
    tick();
    chk("t4_addr_latched", mem_address, 32'h3000_0040);
    wait_idle(20);

    // Directed: reset in the middle of a D read, then a fresh I read.
    lat_fixed = 10;
    req_d(1'b0, 32'h4000_0080, '0);
    tick();
    tick();
    rst = 1'b1; dcache_read = 1'b0; n_req_d--;
    tick();
    chk("t5_rst_mem_read", mem_read, 0);
    chk("t5_rst_mem_write", mem_write, 0);
    rst = 1'b0;
    lat_fixed = 3;
    req_i(32'h5000_0000);
    wait_idle(20);
    chk("t5_i_after_rst", n_resp_i, 2);

    // Directed: simultaneous requests, then again after a lone D transaction.
    lat_fixed = 2;
    req_i(32'h0000_0100);
    req_d(1'b0, 32'h0000_0200, '0);
    tick();
    chk("t3_first_contest", mem_address, 32'h0000_0200);
    wait_idle(20);
    req_d(1'b0, 32'h0000_0300, '0);
    wait_idle(20);
    req_i(32'h0000_0100);
    req_d(1'b0, 32'h0000_0200, '0);
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    exp_addr = 32'h0000_0100;
`else
    exp_addr = 32'h0000_0200;
`endif
    chk("t3_second_contest", mem_address, exp_addr);
    wait_idle(20);

    // Random mixed traffic against the model.
    lat_fixed = 0;
    issued = 0;
    cyc = 0;
    while (issued < 50 && cyc < 5000) begin
      tick();
      cyc++;
      if (!icache_read && !just_dropped_i && ($urandom_range(0, 2) == 0) && issued < 50) begin
        req_i(32'h0001_0000 + 32'($urandom_range(0, 7)) * 32);
        issued++;
      end
      if (!dcache_read && !dcache_write && !just_dropped_d && ($urandom_range(0, 2) == 0) && issued < 50) begin
        for (int k = 0; k < 8; k++) w_line[k*32 +: 32] = $urandom();
        req_d($urandom_range(0, 1) == 1, 32'h0001_0000 + 32'($urandom_range(0, 7)) * 32, w_line);
        issued++;
      end
    end
    chk("rand_issue_budget", issued, 50);
    wait_idle(200);
    chk("resp_count_i", n_resp_i, n_req_i);
    chk("resp_count_d", n_resp_d, n_req_d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
